pic_poll_master: RTL and testbench
==================================

# pic_poll_master

Wishbone initiator that services the 8-bit polled interrupt controller on behalf of the CPU core. When the controller's interrupt line is high, it issues the poll command and reads the poll byte. It then presents a 3-bit vector to the CPU through a request/acknowledge handshake. It also performs CPU-requested interrupt-mask writes, so the CPU never drives the controller's registers directly.

## Interface
- BASE_ADR, 32'h0000_0000, bus address of the interrupt controller (both byte lanes)
- TIMEOUT, 16, max cycles `stb_o` may stay high without `ack_i` before the transaction is aborted (≥2)
- HOLDOFF, 4, idle cycles after a CPU acknowledge before `int_i` is sampled again (≥1)
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- int_i  in  1  interrupt line from the controller
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  write enable
- sel_o  out  4  byte select
- adr_o  out  32  address, always BASE_ADR
- dat_o  out  32  write data
- dat_i  in  32  read data
- ack_i  in  1  slave acknowledge
- irq_req_o  out  1  vector valid toward the CPU
- irq_vec_o  out  3  interrupt vector
- irq_ack_i  in  1  CPU has taken the vector
- mask_req_i  in  1  CPU mask-write request, level, held until done
- mask_i  in  8  mask value
- mask_done_o  out  1  one-cycle pulse when the mask write completes
- err_o  out  1  one-cycle pulse on bus timeout

## Operation
- States: IDLE, CMD, GAP, POLL, DELIVER, HOLD, MASK.
- IDLE:
  - `mask_req_i` → MASK. It has priority over `int_i` when both are high in the same cycle.
  - Otherwise `int_i` → CMD.
- CMD: write with `sel_o`=4'b0001 and `dat_o`=32'h0000_000C (OCW3, poll bit set). On `ack_i` → GAP.
- GAP: one cycle with `cyc_o`/`stb_o` low, then → POLL.
- POLL: read with `sel_o`=4'b0001. On `ack_i`, latch `dat_i[2:0]` into `irq_vec_o`; bits 7:3 are ignored. → DELIVER.
- DELIVER: `irq_req_o`=1 and `irq_vec_o` stable. On `irq_ack_i` → HOLD.
- HOLD: count HOLDOFF cycles, then → IDLE. If `int_i` is still high at that point, a new poll starts.
- MASK: write with `sel_o`=4'b0010 and `dat_o`={16'h0, mask_i, 8'h0}. On `ack_i`, pulse `mask_done_o` and → GAP, then → IDLE.
- Bus transactions:
  - Every transaction starts from a cycle with `stb_o` low. No back-to-back strobes, because the slave's ack is registered and would alias.
  - `ack_i` is ignored while `stb_o` is low.
- Timeout: a timeout counter runs while `stb_o` is high. On reaching TIMEOUT:
  - drop `cyc_o`/`stb_o` and pulse `err_o`;
  - → GAP then → IDLE, abandoning the sequence;
  - a pending `mask_req_i` is retried from IDLE.
- `irq_ack_i` outside DELIVER is ignored.
- `int_i` falling during CMD or POLL does not abort the sequence. The vector read is still delivered.
- `mask_req_i` arriving during an interrupt sequence waits until IDLE.

## Timing
- Reset values (all outputs low/zero): `cyc_o`, `stb_o`, `we_o`=0; `sel_o`, `dat_o`, `irq_vec_o`=0; `irq_req_o`, `mask_done_o`, `err_o`=0; state IDLE, counters 0.
- Reset asserted mid-transaction drops `cyc_o`/`stb_o` immediately, asynchronously.
- `cyc_o`=`stb_o` in all states. Both rise the cycle after the state is entered and fall the cycle after `ack_i` is sampled.
- Latency with a one-wait-state slave, taking the first cycle `int_i` is high as cycle 0:
  - CMD strobe in cycle 1, ack in cycle 2;
  - GAP in cycle 3;
  - POLL strobe in cycle 4, ack in cycle 5;
  - `irq_req_o` high from cycle 6.
- `irq_ack_i` sampled in DELIVER drops `irq_req_o` the next cycle.
- `mask_done_o` is high in the cycle after `ack_i`.

## Structure
- Shared package `pic_pkg` holds:
  - state encoding;
  - OCW3 poll constant 8'h0C;
  - byte-lane constants SEL_CMD=4'b0001 and SEL_IMR=4'b0010.
  The controller and this master both import it.
- Single module. No sub-module is warranted; the timeout and holdoff counters share one counter register.

## Test plan
- Interrupt poll: slave model answers the poll read with 8'h05, `int_i` raised at cycle 0 → CMD write of 8'h0C, one gap cycle, read, `irq_req_o`=1 with `irq_vec_o`=5 in cycle 6; `irq_ack_i` → `irq_req_o`=0 next cycle.
- Mask write: `mask_req_i` with `mask_i`=8'hA5 → write with `sel_o`=4'b0010 and `dat_o`=32'h0000_A500; `mask_done_o` one pulse.
- Mask/interrupt collision: `mask_req_i` and `int_i` rise in the same IDLE cycle → mask write completes before the CMD write starts.
- Timeout: slave never acks, TIMEOUT=16 → `stb_o` drops after 16 cycles, `err_o` pulses once, state returns to IDLE.
- Sticky interrupt: `int_i` held high across `irq_ack_i` → second poll begins HOLDOFF+1 cycles after the acknowledge.
- Reset mid-poll: `rst_n_i` low during the POLL strobe → `cyc_o`/`stb_o` low immediately, all outputs at reset values, no stray `irq_req_o` after release.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared definitions for the polled interrupt controller and its bus master:
// master state encoding, OCW3 poll command and byte-lane selects.
package pic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_GAP,
    ST_POLL,
    ST_DELIVER,
    ST_HOLD,
    ST_MASK
  } state_t;

  localparam logic [7:0] OCW3_POLL = 8'h0C;
  localparam logic [3:0] SEL_CMD   = 4'b0001;
  localparam logic [3:0] SEL_IMR   = 4'b0010;

  // Mask register lives on byte lane 1 of the controller word.
  function automatic logic [31:0] imr_word(input logic [7:0] mask);
    return {16'h0000, mask, 8'h00};
  endfunction

endpackage

// File: rtl/pic_poll_master_if.sv
// Wishbone bus between the poll master and the interrupt controller.
interface pic_poll_master_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;

  modport master (
    output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/pic_poll_master.sv
// Wishbone initiator that polls the interrupt controller, hands the vector to
// the CPU via req/ack, and performs CPU-requested interrupt-mask writes.
module pic_poll_master
  import pic_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          HOLDOFF  = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  pic_poll_master_if.master  wb,
  input  logic               int_i,
  output logic               irq_req_o,
  output logic [2:0]         irq_vec_o,
  input  logic               irq_ack_i,
  input  logic               mask_req_i,
  input  logic [7:0]         mask_i,
  output logic               mask_done_o,
  output logic               err_o
);

  localparam int CNT_MAX = (TIMEOUT > HOLDOFF) ? TIMEOUT : HOLDOFF;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] HO_LAST = CW'(HOLDOFF - 1);

  state_t        state;
  logic [CW-1:0] cnt;        // strobe timeout in bus states, holdoff in HOLD
  logic          poll_next;  // GAP leads to POLL rather than IDLE
  logic          stb;
  logic          we;
  logic [3:0]    sel;
  logic [31:0]   dat;
  logic          ack;
  logic          unused_dat;

  assign wb.cyc_o = stb;
  assign wb.stb_o = stb;
  assign wb.we_o  = we;
  assign wb.sel_o = sel;
  assign wb.dat_o = dat;
  assign wb.adr_o = BASE_ADR;

  // A registered slave ack can linger into a strobe-low cycle; never take it there.
  assign ack        = wb.ack_i & stb;
  assign unused_dat = ^wb.dat_i[31:3];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      poll_next   <= 1'b0;
      stb         <= 1'b0;
      we          <= 1'b0;
      sel         <= '0;
      dat         <= '0;
      irq_req_o   <= 1'b0;
      irq_vec_o   <= '0;
      mask_done_o <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      mask_done_o <= 1'b0;
      err_o       <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (mask_req_i) begin
            state <= ST_MASK;
            stb   <= 1'b1;
            we    <= 1'b1;
            sel   <= SEL_IMR;
            dat   <= imr_word(mask_i);
          end else if (int_i) begin
            state <= ST_CMD;
            stb   <= 1'b1;
            we    <= 1'b1;
            sel   <= SEL_CMD;
            dat   <= {24'h0, OCW3_POLL};
          end
        end

        ST_CMD, ST_POLL, ST_MASK: begin
          if (ack) begin
            stb <= 1'b0;
            we  <= 1'b0;
            sel <= '0;
            dat <= '0;
            cnt <= '0;
            case (state)
              ST_CMD: begin
                poll_next <= 1'b1;
                state     <= ST_GAP;
              end
              ST_POLL: begin
                irq_vec_o <= wb.dat_i[2:0];
                irq_req_o <= 1'b1;
                state     <= ST_DELIVER;
              end
              default: begin
                mask_done_o <= 1'b1;
                state       <= ST_GAP;
              end
            endcase
          end else if (cnt == TO_LAST) begin
            // Abandon the whole sequence; a held mask request retries from IDLE.
            stb   <= 1'b0;
            we    <= 1'b0;
            sel   <= '0;
            dat   <= '0;
            cnt   <= '0;
            err_o <= 1'b1;
            state <= ST_GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_GAP: begin
          poll_next <= 1'b0;
          if (poll_next) begin
            state <= ST_POLL;
            stb   <= 1'b1;
            we    <= 1'b0;
            sel   <= SEL_CMD;
            dat   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_DELIVER: begin
          if (irq_ack_i) begin
            irq_req_o <= 1'b0;
            cnt       <= '0;
            state     <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (cnt == HO_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_poll_master.sv
// Bench for pic_poll_master: directed protocol checks plus randomized traffic
// compared every cycle against a sequential reference model.
module tb_pic_poll_master;
  import pic_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int TO = 16;
  localparam int HO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       int_i, irq_req_o, irq_ack_i, mask_req_i, mask_done_o, err_o;
  logic [2:0] irq_vec_o;
  logic [7:0] mask_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pic_poll_master_if wb();

  pic_poll_master #(.BASE_ADR(BASE), .TIMEOUT(TO), .HOLDOFF(HO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .wb(wb), .int_i(int_i),
    .irq_req_o(irq_req_o), .irq_vec_o(irq_vec_o), .irq_ack_i(irq_ack_i),
    .mask_req_i(mask_req_i), .mask_i(mask_i),
    .mask_done_o(mask_done_o), .err_o(err_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Slave: registered ack one cycle after a strobe, with optional stalls and stray acks.
  bit          stall = 1'b0;
  bit          stray_en = 1'b0;
  bit          fixed_en = 1'b0;
  int unsigned ack_pct = 100;
  logic [31:0] fixed_dat = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.ack_i <= 1'b0;
      wb.dat_i <= 32'h0;
    end else begin
      if (wb.stb_o && !wb.ack_i && !stall && ($urandom_range(0, 99) < ack_pct))
        wb.ack_i <= 1'b1;
      else if (!wb.stb_o && stray_en && ($urandom_range(0, 99) < 5))
        wb.ack_i <= 1'b1;
      else
        wb.ack_i <= 1'b0;
      wb.dat_i <= fixed_en ? fixed_dat : $urandom;
    end
  end

  // Reference model: expected outputs for the cycle following each rising edge.
  logic        m_cyc = 1'b0, m_we = 1'b0, m_req = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic [3:0]  m_sel = 4'h0;
  logic [31:0] m_dat = 32'h0;
  logic [2:0]  m_vec = 3'h0;
  bit          rst_hit = 1'b0;

  task automatic step();
    @(posedge clk);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!rst_n) rst_hit = 1'b1;
  endtask

  task automatic txn(input logic w, input logic [3:0] s, input logic [31:0] d,
                     output bit acked, output logic [31:0] rd);
    int n = 0;
    acked = 1'b0;
    rd    = 32'h0;
    m_cyc = 1'b1; m_we = w; m_sel = s; m_dat = d;
    forever begin
      step();
      if (rst_hit) return;
      if (wb.ack_i) begin
        acked = 1'b1;
        rd    = wb.dat_i;
        break;
      end
      n++;
      if (n == TO) break;
    end
    m_cyc = 1'b0; m_we = 1'b0; m_sel = 4'h0; m_dat = 32'h0;
    if (!acked) m_err = 1'b1;
  endtask

  task automatic do_poll();
    bit ok;
    logic [31:0] rd;
    txn(1'b1, SEL_CMD, {24'h0, OCW3_POLL}, ok, rd);
    if (rst_hit) return;
    step();                       // gap cycle (or the gap before IDLE on timeout)
    if (rst_hit || !ok) return;
    txn(1'b0, SEL_CMD, 32'h0, ok, rd);
    if (rst_hit) return;
    if (!ok) begin
      step();
      return;
    end
    m_req = 1'b1;
    m_vec = rd[2:0];
    forever begin
      step();
      if (rst_hit) return;
      if (irq_ack_i) break;
    end
    m_req = 1'b0;
    repeat (HO) begin
      step();
      if (rst_hit) return;
    end
  endtask

  task automatic do_mask(input logic [7:0] m);
    bit ok;
    logic [31:0] rd;
    txn(1'b1, SEL_IMR, {16'h0, m, 8'h0}, ok, rd);
    if (rst_hit) return;
    if (ok) m_done = 1'b1;
    step();
  endtask

  task automatic run_model();
    forever begin
      step();
      if (rst_hit) return;
      if (mask_req_i) do_mask(mask_i);
      else if (int_i) do_poll();
      if (rst_hit) return;
    end
  endtask

  initial begin
    forever begin
      m_cyc = 1'b0; m_we = 1'b0; m_sel = 4'h0; m_dat = 32'h0;
      m_req = 1'b0; m_vec = 3'h0; m_done = 1'b0; m_err = 1'b0;
      rst_hit = 1'b0;
      wait (rst_n === 1'b1);
      run_model();
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_cyc", 32'(wb.cyc_o), 32'h0);
      chk("rst_stb", 32'(wb.stb_o), 32'h0);
      chk("rst_dat", wb.dat_o, 32'h0);
      chk("rst_sel", 32'(wb.sel_o), 32'h0);
      chk("rst_req", 32'(irq_req_o), 32'h0);
      chk("rst_vec", 32'(irq_vec_o), 32'h0);
      chk("rst_done", 32'(mask_done_o), 32'h0);
      chk("rst_err", 32'(err_o), 32'h0);
    end else begin
      chk("cyc", 32'(wb.cyc_o), 32'(m_cyc));
      chk("stb", 32'(wb.stb_o), 32'(m_cyc));
      chk("adr", wb.adr_o, BASE);
      if (m_cyc) begin
        chk("we", 32'(wb.we_o), 32'(m_we));
        chk("sel", 32'(wb.sel_o), 32'(m_sel));
        chk("dat", wb.dat_o, m_dat);
      end
      chk("irq_req", 32'(irq_req_o), 32'(m_req));
      if (m_req) chk("irq_vec", 32'(irq_vec_o), 32'(m_vec));
      chk("mask_done", 32'(mask_done_o), 32'(m_done));
      chk("err", 32'(err_o), 32'(m_err));
    end
  end

  task automatic wait_req(input string nm);
    int k = 0;
    while (!irq_req_o && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(irq_req_o), 32'h1);
  endtask

  task automatic ack_and_settle();
    irq_ack_i = 1'b1;
    @(negedge clk);
    irq_ack_i = 1'b0;
    repeat (HO + 3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    int_i = 1'b0; irq_ack_i = 1'b0; mask_req_i = 1'b0; mask_i = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_stb", 32'(wb.stb_o), 32'h0);
    chk("reset_req", 32'(irq_req_o), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Interrupt poll; upper poll-byte bits must be ignored (8'hFD -> vector 5)
    fixed_en = 1'b1; fixed_dat = 32'h0000_00FD; ack_pct = 100;
    int_i = 1'b1;
    @(negedge clk);
    chk("t1_c1_stb", 32'(wb.stb_o), 32'h1);
    chk("t1_c1_we", 32'(wb.we_o), 32'h1);
    chk("t1_c1_sel", 32'(wb.sel_o), 32'h1);
    chk("t1_c1_dat", wb.dat_o, 32'h0000_000C);
    @(negedge clk);
    chk("t1_c2_stb", 32'(wb.stb_o), 32'h1);
    int_i = 1'b0;
    @(negedge clk);
    chk("t1_c3_gap", 32'(wb.stb_o), 32'h0);
    @(negedge clk);
    chk("t1_c4_stb", 32'(wb.stb_o), 32'h1);
    chk("t1_c4_we", 32'(wb.we_o), 32'h0);
    @(negedge clk);
    chk("t1_c5_req", 32'(irq_req_o), 32'h0);
    @(negedge clk);
    chk("t1_c6_req", 32'(irq_req_o), 32'h1);
    chk("t1_c6_vec", 32'(irq_vec_o), 32'h5);
    irq_ack_i = 1'b1;
    @(negedge clk);
    chk("t1_c7_req", 32'(irq_req_o), 32'h0);
    irq_ack_i = 1'b0;
    repeat (HO + 3) @(negedge clk);

    // Mask write
    mask_req_i = 1'b1; mask_i = 8'hA5;
    @(negedge clk);
    chk("t2_stb", 32'(wb.stb_o), 32'h1);
    chk("t2_sel", 32'(wb.sel_o), 32'h2);
    chk("t2_dat", wb.dat_o, 32'h0000_A500);
    @(negedge clk);
    chk("t2_c2_done", 32'(mask_done_o), 32'h0);
    @(negedge clk);
    chk("t2_c3_done", 32'(mask_done_o), 32'h1);
    mask_req_i = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (mask_done_o) cnt++;
    end
    chk("t2_done_once", 32'(cnt), 32'h0);

    // Mask and interrupt in the same idle cycle: mask goes first
    mask_req_i = 1'b1; mask_i = 8'h3C; int_i = 1'b1;
    @(negedge clk);
    chk("t3_mask_first", 32'(wb.sel_o), 32'h2);
    repeat (2) @(negedge clk);
    chk("t3_done", 32'(mask_done_o), 32'h1);
    mask_req_i = 1'b0;
    @(negedge clk);
    chk("t3_idle_stb", 32'(wb.stb_o), 32'h0);
    @(negedge clk);
    chk("t3_cmd_stb", 32'(wb.stb_o), 32'h1);
    chk("t3_cmd_sel", 32'(wb.sel_o), 32'h1);
    chk("t3_cmd_dat", wb.dat_o, 32'h0000_000C);
    int_i = 1'b0;
    wait_req("t3_req");
    ack_and_settle();

    // Timeout: slave never acks
    stall = 1'b1; int_i = 1'b1; cnt = 0;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      if (c == 1) int_i = 1'b0;
      if (err_o) cnt++;
      if (c == 16) chk("t4_c16_stb", 32'(wb.stb_o), 32'h1);
      if (c == 17) begin
        chk("t4_c17_stb", 32'(wb.stb_o), 32'h0);
        chk("t4_c17_err", 32'(err_o), 32'h1);
      end
      if (c == 22) chk("t4_idle_stb", 32'(wb.stb_o), 32'h0);
    end
    chk("t4_err_once", 32'(cnt), 32'h1);
    stall = 1'b0;
    repeat (2) @(negedge clk);

    // Sticky interrupt: repoll HOLDOFF+1 cycles after the acknowledge
    int_i = 1'b1;
    wait_req("t5_req");
    irq_ack_i = 1'b1;
    for (int k = 1; k <= HO + 2; k++) begin
      @(negedge clk);
      irq_ack_i = 1'b0;
      if (k <= HO + 1) chk("t5_hold_stb", 32'(wb.stb_o), 32'h0);
      else begin
        chk("t5_repoll_stb", 32'(wb.stb_o), 32'h1);
        chk("t5_repoll_dat", wb.dat_o, 32'h0000_000C);
      end
    end
    int_i = 1'b0;
    wait_req("t5_req2");
    ack_and_settle();

    // Reset during the poll strobe
    int_i = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_poll_stb", 32'(wb.stb_o), 32'h1);
    chk("t6_poll_we", 32'(wb.we_o), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_cyc", 32'(wb.cyc_o), 32'h0);
    chk("t6_async_stb", 32'(wb.stb_o), 32'h0);
    int_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("t6_no_req", 32'(irq_req_o), 32'h0);
    end

    // Randomized traffic
    fixed_en = 1'b0; stray_en = 1'b1; ack_pct = 60;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) < 8) int_i = ~int_i;
      irq_ack_i = ($urandom_range(0, 99) < 30);
      if (mask_req_i) begin
        if (mask_done_o) mask_req_i = 1'b0;
      end else if ($urandom_range(0, 99) < 3) begin
        mask_req_i = 1'b1;
        mask_i = 8'($urandom);
      end
      if (stall) begin
        if ($urandom_range(0, 99) < 5) stall = 1'b0;
      end else if ($urandom_range(0, 999) < 5) begin
        stall = 1'b1;
      end
    end

    // Drain outstanding work
    stall = 1'b0; stray_en = 1'b0; int_i = 1'b0; irq_ack_i = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (mask_done_o) mask_req_i = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
